// File: rtl/onehot10_bcd_encoder.sv
// Ten-line key encoder: sync + debounce, one 4-bit code per press (BCD, or excess-3 with XS3_OUT_EN).
// Latency: code_valid rises STABLE_CYCLES+2 edges after key_in goes nonzero; code held until code_ready.
// Backpressure: valid/ready; a pending code is never withdrawn, and err is a single-cycle pulse.
module onehot10_bcd_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_in,
  input  logic       code_ready,
  output logic [3:0] code_out,
  output logic       code_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, RELEASE} state_t;

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  state_t     state;
  logic [9:0] key_m;
  logic [9:0] key_s;
  logic [9:0] key_cap;
  logic [7:0] cnt;
  logic       cap_onehot;
  logic [3:0] code_nxt;

  function automatic logic [3:0] bit_index(input logic [9:0] k);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign cap_onehot = (key_cap != 10'd0) && ((key_cap & (key_cap - 10'd1)) == 10'd0);

`ifdef XS3_OUT_EN
  assign code_nxt = bit_index(key_cap) + 4'd3;
`else
  assign code_nxt = bit_index(key_cap);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m      <= '0;
      key_s      <= '0;
      key_cap    <= '0;
      cnt        <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      err        <= 1'b0;
      state      <= IDLE;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s != 10'd0) begin
            key_cap <= key_s;
            cnt     <= 8'd1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (key_s == 10'd0) begin
            state <= IDLE;
          end else if (key_s != key_cap) begin
            key_cap <= key_s;
            cnt     <= 8'd1;
          end else if (cnt < LAST) begin
            cnt <= cnt + 8'd1;
          end else if (cap_onehot) begin
            code_out   <= code_nxt;
            code_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            err   <= 1'b1;
            cnt   <= 8'd0;
            state <= RELEASE;
          end
        end
        HOLD: begin
          // Key activity is ignored here; only the handshake releases the code.
          if (code_ready) begin
            code_valid <= 1'b0;
            cnt        <= 8'd0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_s != 10'd0) begin
            cnt <= 8'd0;
          end else if (cnt >= LAST) begin
            cnt   <= 8'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot10_bcd_encoder.sv
// Bench for onehot10_bcd_encoder: directed scenarios plus random key traffic against a
// sample-window model (a press is accepted once the last STABLE_CYCLES synced samples agree).
module tb_onehot10_bcd_encoder;

  localparam int S = 4;
`ifdef XS3_OUT_EN
  localparam logic [3:0] OFS = 4'd3;
`else
  localparam logic [3:0] OFS = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key_in = '0;
  logic       code_ready = 1'b0;
  logic [3:0] code_out;
  logic       code_valid;
  logic       err;
  logic       busy;

  onehot10_bcd_encoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .code_ready (code_ready),
    .code_out   (code_out),
    .code_valid (code_valid),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [9:0] m1, ms;
  logic [9:0] hist[$];
  logic       e_valid, e_err, e_busy, in_rel;
  logic [3:0] e_code;
  int         zrun;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1 = '0; ms = '0;
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(10'd0);
    e_valid = 1'b0; e_err = 1'b0; e_busy = 1'b0; in_rel = 1'b0;
    e_code = 4'd0; zrun = 0;
  endtask

  task automatic tick();
    logic [9:0] s;
    logic       agree;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = ms; ms = m1; m1 = key_in;
      hist.push_back(s);
      void'(hist.pop_front());
      e_err = 1'b0;
      if (e_valid) begin
        if (code_ready) begin e_valid = 1'b0; in_rel = 1'b1; zrun = 0; end
      end else if (in_rel) begin
        if (s == 10'd0) begin
          zrun++;
          if (zrun >= S) in_rel = 1'b0;
        end else zrun = 0;
      end else begin
        agree = (s != 10'd0);
        foreach (hist[i]) if (hist[i] != s) agree = 1'b0;
        if (agree) begin
          if ($countones(s) == 1) begin
            e_valid = 1'b1;
            e_code  = 4'($clog2(s)) + OFS;
          end else e_err = 1'b1;
          in_rel = 1'b1; zrun = 0;
        end
      end
      e_busy = e_valid || in_rel || (s != 10'd0);
    end
    #1;
    chk("code_valid", {9'd0, code_valid}, {9'd0, e_valid});
    chk("code_out",   {6'd0, code_out},   {6'd0, e_code});
    chk("err",        {9'd0, err},        {9'd0, e_err});
    chk("busy",       {9'd0, busy},       {9'd0, e_busy});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nvalid, nerr;
    logic [9:0] k;
    model_reset();

    // Reset state
    #2;
    chk("rst_code_out", {6'd0, code_out}, 10'd0);
    chk("rst_valid", {9'd0, code_valid}, 10'd0);
    chk("rst_busy", {9'd0, busy}, 10'd0);
    chk("rst_err", {9'd0, err}, 10'd0);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    repeat (2) tick();

    // 1: bit5 held 20 cycles with ready high -> one code, 6 edges latency
    code_ready = 1'b1;
    key_in = 10'b0000100000;
    n = 0; nvalid = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (code_valid) begin
        nvalid++;
        if (n == 0) begin n = i; chk("t1_code", {6'd0, code_out}, {6'd0, 4'd5 + OFS}); end
      end
    end
    chk("t1_latency", 10'(n), 10'd6);
    chk("t1_valid_count", 10'(nvalid), 10'd1);
    key_in = '0;
    repeat (8) tick();

    // 2: bit9 with ready low, released while pending; code held until accepted
    code_ready = 1'b0;
    key_in = 10'b1000000000;
    repeat (8) tick();
    key_in = '0;
    repeat (6) tick();
    chk("t2_held_valid", {9'd0, code_valid}, 10'd1);
    chk("t2_held_code", {6'd0, code_out}, {6'd0, 4'd9 + OFS});
    code_ready = 1'b1;
    tick();
    chk("t2_after_xfer", {9'd0, code_valid}, 10'd0);
    repeat (6) tick();

    // 3: bit3 toggling, then held
    nvalid = 0; nerr = 0;
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 10'b0000001000 : 10'd0;
      tick();
      nvalid += int'(code_valid);
      nerr += int'(err);
    end
    chk("t3_toggle_quiet", 10'(nvalid + nerr), 10'd0);
    key_in = 10'b0000001000;
    repeat (12) tick();
    key_in = '0;
    repeat (8) tick();

    // 4: multi-hot press -> single err pulse, no valid
    key_in = 10'b0000000101;
    nvalid = 0; nerr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nvalid += int'(code_valid);
      nerr += int'(err);
    end
    chk("t4_err_count", 10'(nerr), 10'd1);
    chk("t4_no_valid", 10'(nvalid), 10'd0);
    chk("t4_busy_held", {9'd0, busy}, 10'd1);
    key_in = '0;
    repeat (8) tick();

    // 5: async reset while holding bit7, then fresh press after reset
    code_ready = 1'b0;
    key_in = 10'b0010000000;
    repeat (8) tick();
    chk("t5_hold_code", {6'd0, code_out}, {6'd0, 4'd7 + OFS});
    rst_n = 1'b0;
    #2;
    chk("t5_rst_valid", {9'd0, code_valid}, 10'd0);
    chk("t5_rst_busy", {9'd0, busy}, 10'd0);
    chk("t5_rst_code", {6'd0, code_out}, 10'd0);
    model_reset();
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      tick();
      if (code_valid) n = i;
    end
    chk("t5_relatency", 10'(n), 10'd6);
    code_ready = 1'b1;
    key_in = '0;
    repeat (8) tick();

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: k = '0;
        1, 2: begin k = '0; k[$urandom_range(0, 9)] = 1'b1; end
        default: k = 10'($urandom);
      endcase
      key_in = k;
      repeat ($urandom_range(1, 8)) begin
        code_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
